modulator_tx_scheduler: RTL and testbench

Transmit scheduler sitting in front of the DigitalModulator. It arbitrates between two requesters (switch-panel and host port), latches the winner's mode/message/cnt, and drives the modulator's send/mode/message/cnt inputs. It sequences one frame per grant: hold send for a fixed window, then enforce a guard time covering the full modulated frame before the next grant.

---
 rtl/modulator_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/modulator_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_modulator_tx_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulator_pkg.sv
// Shared definitions for the modulator transmit path: scheduler state encoding
// and the default frame timing used by the modulator top-level.
package modulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2
    } sched_state_e;

    localparam int SEND_HOLD_DEF    = 5000;
    localparam int FRAME_CYCLES_DEF = 3000000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered last winner.
// last_id resets to 1 so requester 0 takes the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt,
    output logic       o_valid,
    output logic       o_winner
);

    logic r_last_id;
    logic w_winner;

    always_comb begin
        if (i_req == 2'b11) begin
            w_winner = ~r_last_id;
        end else begin
            w_winner = i_req[1];
        end
    end

    assign o_valid  = |i_req;
    assign o_winner = w_winner;
    assign o_gnt    = o_valid ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id <= 1'b1;
        end else if (i_accept && o_valid) begin
            r_last_id <= w_winner;
        end
    end

endmodule

// File: rtl/modulator_tx_scheduler.sv
// Transmit scheduler: arbitrates two requesters, latches the winner's settings
// and sequences one send window plus guard time per grant.
module modulator_tx_scheduler
    import modulator_pkg::*;
#(
    parameter int SEND_HOLD    = SEND_HOLD_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int CW           = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       mode0,
    input  logic       mode1,
    input  logic [4:0] msg0,
    input  logic [4:0] msg1,
    input  logic [2:0] cnt0,
    input  logic [2:0] cnt1,
    input  logic       abort,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       mod_send,
    output logic       mod_mode,
    output logic [4:0] mod_message,
    output logic [2:0] mod_cnt,
    output logic       done,
    output logic       done_id
);

    localparam logic [CW-1:0] SEND_LAST  = CW'(SEND_HOLD - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(FRAME_CYCLES - 1);

    sched_state_e r_state;
    sched_state_e w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic        r_cur_id;
    logic [1:0]  r_gnt;
    logic        r_busy;
    logic        r_send;
    logic        r_mode;
    logic [4:0]  r_message;
    logic [2:0]  r_cnt_sel;
    logic        r_done;
    logic        r_done_id;

    logic [1:0]  w_arb_gnt;
    logic        w_arb_valid;
    logic        w_arb_winner;
    logic        w_grant;
    logic        w_send_term;
    logic        w_guard_term;
    logic        w_finish;
    logic [1:0]  w_gnt_nxt;
    logic        w_send_nxt;
    logic        w_busy_nxt;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req),
        .i_accept (w_grant),
        .o_gnt    (w_arb_gnt),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_winner)
    );

    assign w_grant      = (r_state == ST_IDLE) && w_arb_valid;
    assign w_send_term  = (r_state == ST_SEND) && (r_cnt == SEND_LAST);
    // Guard time is counted from the cycle mod_send actually drops.
    assign w_guard_term = (r_state == ST_GUARD) && !r_send && (r_cnt == GUARD_LAST);
    assign w_finish     = (r_state != ST_IDLE) && (abort || w_guard_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_nxt = ST_SEND;
            ST_SEND:  if (abort) w_state_nxt = ST_IDLE;
                      else if (w_send_term) w_state_nxt = ST_GUARD;
            ST_GUARD: if (w_finish) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt  = w_grant ? w_arb_gnt : 2'b00;
        w_send_nxt = (r_state == ST_SEND) && !abort;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_grant || w_finish || w_send_term) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SEND) || ((r_state == ST_GUARD) && !r_send)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_send    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_cur_id  <= 1'b0;
            r_mode    <= 1'b0;
            r_message <= 5'd0;
            r_cnt_sel <= 3'd0;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_busy <= w_busy_nxt;
            r_send <= w_send_nxt;
            r_done <= w_finish;
            if (w_finish) begin
                r_done_id <= r_cur_id;
            end
            if (w_grant) begin
                r_cur_id  <= w_arb_winner;
                r_mode    <= w_arb_winner ? mode1 : mode0;
                r_message <= w_arb_winner ? msg1 : msg0;
                r_cnt_sel <= w_arb_winner ? cnt1 : cnt0;
            end
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign mod_send    = r_send;
    assign mod_mode    = r_mode;
    assign mod_message = r_message;
    assign mod_cnt     = r_cnt_sel;
    assign done        = r_done;
    assign done_id     = r_done_id;

endmodule

// File: tb/tb_modulator_tx_scheduler.sv
// Directed bench for modulator_tx_scheduler with SEND_HOLD=4, FRAME_CYCLES=10.
module tb_modulator_tx_scheduler;

    localparam int SH = 4;
    localparam int FC = 10;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       mode0, mode1;
    logic [4:0] msg0, msg1;
    logic [2:0] cnt0, cnt1;
    logic       abort;
    logic [1:0] gnt;
    logic       busy;
    logic       mod_send;
    logic       mod_mode;
    logic [4:0] mod_message;
    logic [2:0] mod_cnt;
    logic       done;
    logic       done_id;

    int n_pass;
    int n_total;

    modulator_tx_scheduler #(
        .SEND_HOLD    (SH),
        .FRAME_CYCLES (FC),
        .CW           (22)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mode0       (mode0),
        .mode1       (mode1),
        .msg0        (msg0),
        .msg1        (msg1),
        .cnt0        (cnt0),
        .cnt1        (cnt1),
        .abort       (abort),
        .gnt         (gnt),
        .busy        (busy),
        .mod_send    (mod_send),
        .mod_mode    (mod_mode),
        .mod_message (mod_message),
        .mod_cnt     (mod_cnt),
        .done        (done),
        .done_id     (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},     32'(gnt), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_send"},    32'(mod_send), 32'd0);
        chk({tag, "_mode"},    32'(mod_mode), 32'd0);
        chk({tag, "_msg"},     32'(mod_message), 32'd0);
        chk({tag, "_cnt"},     32'(mod_cnt), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
    endtask

    initial begin
        logic [31:0] acc;
        int          hi;
        int          k;
        int          w;
        logic [1:0]  exp_gnt [3];

        n_pass  = 0;
        n_total = 0;
        rst   = 1'b1;
        req   = 2'b00;
        abort = 1'b0;
        mode0 = 1'b0;  msg0 = 5'b10101; cnt0 = 3'd3;
        mode1 = 1'b1;  msg1 = 5'b01110; cnt1 = 3'd5;
        tick();
        tick();
        chk_reset_outputs("reset");

        // Quiet idle after reset release
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc = acc | 32'({gnt, busy, mod_send, mod_mode, mod_message, mod_cnt, done, done_id});
        end
        chk("idle_quiet", acc, 32'd0);

        // Single frame from requester 0
        req = 2'b01;
        tick();
        chk("f1_gnt", 32'(gnt), 32'b01);
        chk("f1_msg", 32'(mod_message), 32'b10101);
        chk("f1_cnt", 32'(mod_cnt), 32'd3);
        chk("f1_mode", 32'(mod_mode), 32'd0);
        chk("f1_send_latency", 32'(mod_send), 32'd0);
        chk("f1_busy", 32'(busy), 32'd1);
        req = 2'b00;
        tick();
        chk("f1_gnt_pulse", 32'(gnt), 32'd0);
        chk("f1_send_rise", 32'(mod_send), 32'd1);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mod_send) hi++;
            else break;
        end
        chk("f1_send_len", 32'(hi), 32'(SH));
        k = 0;
        while (!done && k < 50) begin
            tick();
            k++;
        end
        chk("f1_done_delay", 32'(k), 32'(FC));
        chk("f1_done_id", 32'(done_id), 32'd0);
        chk("f1_done_busy", 32'(busy), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(done), 32'd0);

        // Both requesting: last winner was 0, so 1 goes first
        exp_gnt[0] = 2'b10;
        exp_gnt[1] = 2'b01;
        exp_gnt[2] = 2'b10;
        req = 2'b11;
        for (int g = 0; g < 3; g++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (gnt == 2'b00 && w < 40);
            chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(exp_gnt[g]));
            chk($sformatf("rr%0d_interval", g), 32'(w), (g == 0) ? 32'd1 : 32'(1 + SH + FC + 1));
            chk($sformatf("rr%0d_mode", g), 32'(mod_mode), exp_gnt[g][1] ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_msg", g), 32'(mod_message), exp_gnt[g][1] ? 32'b01110 : 32'b10101);
            chk($sformatf("rr%0d_cnt", g), 32'(mod_cnt), exp_gnt[g][1] ? 32'd5 : 32'd3);
        end
        req = 2'b00;

        // Abort on the second SEND cycle, with a pending request
        req = 2'b01;
        tick();
        chk("ab_send_on", 32'(mod_send), 32'd1);
        chk("ab_busy_ignored_req", 32'(gnt), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_send_off", 32'(mod_send), 32'd0);
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_done_id", 32'(done_id), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        tick();
        chk("ab_regrant", 32'(gnt), 32'b01);
        chk("ab_regrant_msg", 32'(mod_message), 32'b10101);
        chk("ab_done_pulse", 32'(done), 32'd0);
        req = 2'b00;

        // Abort coincident with the last guard cycle
        for (int i = 0; i < SH + FC; i++) tick();
        chk("abt_pre_done", 32'(done), 32'd0);
        chk("abt_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_done", 32'(done), 32'd1);
        chk("abt_done_id", 32'(done_id), 32'd0);
        chk("abt_busy", 32'(busy), 32'd0);
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | 32'({done, busy});
        end
        chk("abt_single_done", acc, 32'd0);

        // Reset in the middle of GUARD
        req = 2'b11;
        tick();
        chk("rs_gnt", 32'(gnt), 32'b10);
        req = 2'b00;
        for (int i = 0; i < SH + 3; i++) tick();
        chk("rs_in_guard", 32'({busy, mod_send}), 32'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rs");
        acc = '0;
        for (int i = 0; i < FC + 5; i++) begin
            tick();
            acc = acc | 32'({done, busy, mod_send});
        end
        chk("rs_no_done", acc, 32'd0);
        req = 2'b11;
        tick();
        chk("rs_tie_gnt", 32'(gnt), 32'b01);
        chk("rs_tie_msg", 32'(mod_message), 32'b10101);
        req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
